// File: rtl/tx_pkt_pkg.sv
// Shared constants and types for the host-link transmit framer.
// Frame layout: 8-byte header, 24-bit little-endian length, 0x00, payload.
package tx_pkt_pkg;

    localparam int LEN_W = 24;

    localparam logic [0:7][7:0] HDR_BYTES = {
        8'hEB, 8'h9A, 8'hFC, 8'h1D, 8'h98, 8'h30, 8'hB7, 8'h06
    };

    typedef enum logic [2:0] {
        FILL,
        HDR,
        LEN,
        ZERO,
        DATA
    } state_t;

endpackage

// File: rtl/tx_pkt_buf.sv
// Payload buffer: simple dual-port RAM, one write port, one synchronous read port.
module tx_pkt_buf #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/tx_build_packet.sv
// Host-link packet framer: buffers a byte stream, then emits header, length, 0x00, payload.
// Optional idle-flush of partial packets is enabled with TX_PKT_TIMEOUT_EN.
module tx_build_packet
    import tx_pkt_pkg::*;
#(
    parameter int BUF_AW      = 12,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [7:0] i_data,
    input  logic       i_last,
    output logic       i_rdy,
    output logic       o_en,
    output logic [7:0] o_data,
    input  logic       o_rdy,
    output logic       during_packet
);

    localparam int CW = BUF_AW + 1;
    localparam logic [CW-1:0] DEPTH = {1'b1, {BUF_AW{1'b0}}};

    state_t            state;
    state_t            state_nxt;
    logic              armed;
    logic [2:0]        idx;
    logic [CW-1:0]     count;
    logic [CW-1:0]     cnt_inc;
    logic [CW-1:0]     rptr;
    logic [CW-1:0]     rptr_nxt;
    logic [7:0]        rdata;
    logic [LEN_W-1:0]  len_vec;
    logic              accept;
    logic              close;
    logic              timeout;
    logic              slot;
    logic              data_done;
    logic              en_nxt;
    logic [7:0]        byte_nxt;

    assign i_rdy         = armed && (state == FILL);
    assign accept        = i_en && i_rdy;
    assign cnt_inc       = count + CW'(1);
    assign close         = (accept && (i_last || cnt_inc == DEPTH)) || timeout;
    assign slot          = !o_en || o_rdy;
    assign data_done     = (rptr == count);
    assign len_vec       = LEN_W'(count);
    assign during_packet = o_en;

`ifdef TX_PKT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] idle;

    assign timeout = (state == FILL) && !accept && (count != '0)
                     && (idle == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle <= '0;
        end else if (state != FILL || accept || timeout) begin
            idle <= '0;
        end else if (count != '0) begin
            idle <= idle + TW'(1);
        end
    end
`else
    // Never true for a legal TIMEOUT_CYC; folds to a constant.
    assign timeout = (TIMEOUT_CYC < 0);
`endif

    tx_pkt_buf #(
        .AW (BUF_AW)
    ) u_buf (
        .clk   (clk),
        .we    (accept),
        .waddr (count[BUF_AW-1:0]),
        .wdata (i_data),
        .raddr (rptr_nxt[BUF_AW-1:0]),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            FILL:    if (close) state_nxt = HDR;
            HDR:     if (slot && idx == 3'd7) state_nxt = LEN;
            LEN:     if (slot && idx == 3'd2) state_nxt = ZERO;
            ZERO:    if (slot) state_nxt = DATA;
            DATA:    if (slot && data_done) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        en_nxt   = o_en;
        byte_nxt = o_data;
        unique case (state)
            FILL: begin
                if (close) begin
                    en_nxt   = 1'b1;
                    byte_nxt = HDR_BYTES[0];
                end
            end
            HDR:  if (slot) byte_nxt = HDR_BYTES[idx];
            LEN:  if (slot) byte_nxt = len_vec[{idx[1:0], 3'b000} +: 8];
            ZERO: if (slot) byte_nxt = 8'h00;
            DATA: begin
                if (slot) begin
                    if (data_done) en_nxt   = 1'b0;
                    else           byte_nxt = rdata;
                end
            end
            default: ;
        endcase
    end

    // rdata always holds buffer[rptr], so the next payload byte is ready on load.
    always_comb begin
        rptr_nxt = rptr;
        if (state == DATA && slot) begin
            rptr_nxt = data_done ? '0 : rptr + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed  <= 1'b0;
            o_en   <= 1'b0;
            o_data <= 8'h00;
            idx    <= '0;
            count  <= '0;
            rptr   <= '0;
        end else begin
            armed  <= 1'b1;
            o_en   <= en_nxt;
            o_data <= byte_nxt;
            rptr   <= rptr_nxt;
            if (accept) begin
                count <= cnt_inc;
            end else if (state == DATA && slot && data_done) begin
                count <= '0;
            end
            if (state == FILL && close) begin
                idx <= 3'd1;
            end else if (state == HDR && slot) begin
                idx <= (idx == 3'd7) ? 3'd0 : idx + 3'd1;
            end else if (state == LEN && slot) begin
                idx <= (idx == 3'd2) ? 3'd0 : idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_tx_build_packet.sv
// Directed bench for tx_build_packet: one default-size instance, one 16-byte-buffer instance.
module tb_tx_build_packet;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_en   [2];
    logic [7:0] i_data [2];
    logic       i_last [2];
    logic       i_rdy  [2];
    logic       o_en   [2];
    logic [7:0] o_data [2];
    logic       o_rdy  [2];
    logic       dp     [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int dp_x0  = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] pay[$];
    logic [7:0] hb [8] = '{8'hEB, 8'h9A, 8'hFC, 8'h1D, 8'h98, 8'h30, 8'hB7, 8'h06};

    bit         rnd_on  = 0;
    bit         stab_on = 0;
    bit         irdy_on = 0;
    bit         hold0   = 0;
    logic [7:0] hold_d0 = 8'h00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tx_build_packet #(.BUF_AW(12), .TIMEOUT_CYC(50)) u0 (
        .clk(clk), .rst(rst),
        .i_en(i_en[0]), .i_data(i_data[0]), .i_last(i_last[0]), .i_rdy(i_rdy[0]),
        .o_en(o_en[0]), .o_data(o_data[0]), .o_rdy(o_rdy[0]), .during_packet(dp[0])
    );

    tx_build_packet #(.BUF_AW(4)) u1 (
        .clk(clk), .rst(rst),
        .i_en(i_en[1]), .i_data(i_data[1]), .i_last(i_last[1]), .i_rdy(i_rdy[1]),
        .o_en(o_en[1]), .o_data(o_data[1]), .o_rdy(o_rdy[1]), .during_packet(dp[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (o_en[0] && o_rdy[0]) begin
            q0.push_back(o_data[0]);
            if (dp[0]) dp_x0++;
        end
        if (o_en[1] && o_rdy[1]) q1.push_back(o_data[1]);
        if (stab_on && hold0) chk("hold_stable", {23'd0, o_en[0], o_data[0]}, {23'd0, 1'b1, hold_d0});
        hold0   = o_en[0] && !o_rdy[0];
        hold_d0 = o_data[0];
        if (irdy_on && dp[1]) chk("irdy_low_in_frame", {31'd0, i_rdy[1]}, 0);
    end

    always @(posedge clk) begin
        if (rnd_on) begin
            #1;
            o_rdy[0] = 1'($urandom_range(0, 1));
        end
    end

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push(input int d, input logic [7:0] b, input logic last);
        int n = 0;
        while (!i_rdy[d] && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 5000) chk("push_wait_irdy", 0, 1);
        i_en[d]   = 1'b1;
        i_data[d] = b;
        i_last[d] = last;
        @(posedge clk); #1;
        i_en[d]   = 1'b0;
        i_last[d] = 1'b0;
    endtask

    task automatic wait_frame(input string name, input int d, input int nbytes);
        int k = 0;
        while ((qsize(d) < nbytes || o_en[d]) && k < 5000) begin
            @(posedge clk); #1;
            k++;
        end
        chk({name, "_done"}, {31'd0, k < 5000}, 1);
    endtask

    task automatic chk_frame(input string name, input int d);
        logic [7:0] exp[$];
        logic [7:0] obs[$];
        int n   = pay.size();
        int bad = 0;
        int m;
        for (int i = 0; i < 8; i++) exp.push_back(hb[i]);
        exp.push_back(n[7:0]);
        exp.push_back(n[15:8]);
        exp.push_back(n[23:16]);
        exp.push_back(8'h00);
        foreach (pay[i]) exp.push_back(pay[i]);
        if (d == 0) obs = q0;
        else        obs = q1;
        chk({name, "_size"}, obs.size(), exp.size());
        m = (obs.size() < exp.size()) ? obs.size() : exp.size();
        for (int i = 0; i < m; i++) if (obs[i] !== exp[i]) bad++;
        chk({name, "_bytes_bad"}, bad, 0);
    endtask

    typedef struct {
        logic       en;
        logic [7:0] data;
        logic       last;
        logic       x_en;
        logic [7:0] x_data;
        logic       x_rdy;
        logic       x_dp;
    } vec_t;

    vec_t       tv [15];
    logic [7:0] f1 [13] = '{8'hEB, 8'h9A, 8'hFC, 8'h1D, 8'h98, 8'h30, 8'hB7, 8'h06,
                           8'h01, 8'h00, 8'h00, 8'h00, 8'h5A};

    initial begin
        #500000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            i_en[d] = 0; i_data[d] = 0; i_last[d] = 0; o_rdy[d] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_i_rdy",  {31'd0, i_rdy[d]}, 0);
            chk("rst_o_en",   {31'd0, o_en[d]}, 0);
            chk("rst_o_data", {24'd0, o_data[d]}, 0);
            chk("rst_dp",     {31'd0, dp[d]}, 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // single byte frame, cycle-accurate table
        tv[0] = '{1'b1, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        for (int r = 1; r < 14; r++) tv[r] = '{1'b0, 8'h00, 1'b0, 1'b1, f1[r-1], 1'b0, 1'b1};
        tv[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        o_rdy[0] = 1'b1;
        o_rdy[1] = 1'b1;
        q0.delete();
        dp_x0 = 0;
        for (int r = 0; r < 15; r++) begin
            i_en[0] = tv[r].en; i_data[0] = tv[r].data; i_last[0] = tv[r].last;
            @(negedge clk);
            chk($sformatf("t1_o_en_r%0d", r),  {31'd0, o_en[0]},  {31'd0, tv[r].x_en});
            chk($sformatf("t1_i_rdy_r%0d", r), {31'd0, i_rdy[0]}, {31'd0, tv[r].x_rdy});
            chk($sformatf("t1_dp_r%0d", r),    {31'd0, dp[0]},    {31'd0, tv[r].x_dp});
            if (tv[r].x_en) chk($sformatf("t1_o_data_r%0d", r), {24'd0, o_data[0]}, {24'd0, tv[r].x_data});
            @(posedge clk); #1;
        end
        i_en[0] = 0; i_last[0] = 0;
        chk("t1_dp_transfers", dp_x0, 13);

        // 300 bytes with random backpressure
        q0.delete();
        pay.delete();
        rnd_on  = 1;
        stab_on = 1;
        for (int i = 0; i < 300; i++) begin
            pay.push_back(8'(i));
            push(0, 8'(i), i == 299);
        end
        wait_frame("t2", 0, 312);
        rnd_on  = 0;
        stab_on = 0;
        @(posedge clk); #2;
        o_rdy[0] = 1'b1;
        chk_frame("t2", 0);
        if (q0.size() >= 11) begin
            chk("t2_len0", {24'd0, q0[8]},  32'h2C);
            chk("t2_len1", {24'd0, q0[9]},  32'h01);
            chk("t2_len2", {24'd0, q0[10]}, 32'h00);
        end

        // buffer-full close on the 16-byte instance
        q1.delete();
        pay.delete();
        irdy_on = 1;
        for (int i = 0; i < 20; i++) begin
            if (i < 16) pay.push_back(8'h40 + 8'(i));
            push(1, 8'h40 + 8'(i), 1'b0);
        end
        wait_frame("t3a", 1, 28);
        chk_frame("t3a", 1);
        q1.delete();
        pay.delete();
        for (int i = 16; i < 20; i++) pay.push_back(8'h40 + 8'(i));
        pay.push_back(8'h99);
        push(1, 8'h99, 1'b1);
        wait_frame("t3b", 1, 17);
        chk_frame("t3b", 1);
        irdy_on = 0;

        // reset in the middle of the payload
        q0.delete();
        for (int i = 0; i < 10; i++) push(0, 8'h60 + 8'(i), i == 9);
        begin
            int k = 0;
            while (q0.size() < 17 && k < 1000) begin
                @(posedge clk); #1;
                k++;
            end
            chk("t4_reach_data", {31'd0, k < 1000}, 1);
        end
        #2;
        rst = 1'b1;
        #1;
        chk("t4_async_o_en", {31'd0, o_en[0]}, 0);
        chk("t4_async_dp",   {31'd0, dp[0]}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        q0.delete();
        pay.delete();
        pay.push_back(8'hA5);
        push(0, 8'hA5, 1'b1);
        wait_frame("t4", 0, 13);
        chk_frame("t4", 0);

        // byte offered while not ready is dropped
        q0.delete();
        pay.delete();
        pay.push_back(8'h11);
        pay.push_back(8'h22);
        push(0, 8'h11, 1'b0);
        push(0, 8'h22, 1'b1);
        chk("t5_irdy_hdr", {31'd0, i_rdy[0]}, 0);
        i_en[0] = 1'b1; i_data[0] = 8'hEE; i_last[0] = 1'b1;
        @(posedge clk); #1;
        i_en[0] = 1'b0; i_last[0] = 1'b0;
        wait_frame("t5a", 0, 14);
        chk_frame("t5a", 0);
        q0.delete();
        pay.delete();
        pay.push_back(8'h33);
        push(0, 8'h33, 1'b1);
        wait_frame("t5b", 0, 13);
        chk_frame("t5b", 0);

`ifdef TX_PKT_TIMEOUT_EN
        q0.delete();
        pay.delete();
        for (int i = 0; i < 3; i++) begin
            pay.push_back(8'h70 + 8'(i));
            push(0, 8'h70 + 8'(i), 1'b0);
        end
        begin
            int c0 = cyc;
            int k  = 0;
            while (!o_en[0] && k < 200) begin
                @(posedge clk); #1;
                k++;
            end
            chk("t6_timeout_delay", cyc - c0, 50);
        end
        wait_frame("t6", 0, 15);
        chk_frame("t6", 0);
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
